// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
// Shares one single-port memory between the fetch (IF) and data (DM) stages.
// One transaction runs at a time: the requester is sampled in IDLE, the memory
// port is driven for MEM_LAT cycles in BUSY, and a one-cycle ready pulse is
// issued in RESP. Under contention the grant alternates, and DM goes first
// after reset.
module unified_mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              stall_f,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CNT_W = $clog2(MEM_LAT) + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_DM = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t            state_r;
    state_t            next_state_s;
    logic              grant_r;
    logic              last_grant_r;
    logic [ADDR_W-1:0] addr_r;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_ready_r;
    logic              dm_ready_r;
    logic              any_req_s;
    logic              pick_dm_s;
    logic              mem_en_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;

    // Arbitration: DM wins unless it had the previous grant and IF is waiting.
    always_comb begin
        any_req_s = if_req | dm_req;
        if (dm_req && if_req) begin
            pick_dm_s = (last_grant_r != GNT_DM);
        end else begin
            pick_dm_s = dm_req;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic: sample in IDLE, count out the latency in BUSY, one RESP cycle.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) begin
                    next_state_s = ST_BUSY;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_r == CNT_ZERO) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_BUSY;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Memory port outputs: driven from the latched transaction only while BUSY, else zero.
    always_comb begin
        mem_en_s    = 1'b0;
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        case (state_r)
            ST_BUSY: begin
                mem_en_s    = 1'b1;
                mem_we_s    = we_r & (grant_r == GNT_DM);
                mem_addr_s  = addr_r;
                mem_wdata_s = wdata_r;
            end
            default: begin
                mem_en_s    = 1'b0;
                mem_we_s    = 1'b0;
                mem_addr_s  = {ADDR_W{1'b0}};
                mem_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Transaction latches, latency counter, read-data capture and ready pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r      <= GNT_IF;
            last_grant_r <= GNT_IF;
            addr_r       <= {ADDR_W{1'b0}};
            we_r         <= 1'b0;
            wdata_r      <= {DATA_W{1'b0}};
            cnt_r        <= CNT_ZERO;
            if_rdata_r   <= {DATA_W{1'b0}};
            dm_rdata_r   <= {DATA_W{1'b0}};
            if_ready_r   <= 1'b0;
            dm_ready_r   <= 1'b0;
        end else begin
            if_ready_r <= 1'b0;
            dm_ready_r <= 1'b0;
            if ((state_r == ST_IDLE) && any_req_s) begin
                grant_r      <= pick_dm_s;
                last_grant_r <= pick_dm_s;
                addr_r       <= pick_dm_s ? dm_addr : if_addr;
                we_r         <= pick_dm_s & dm_we;
                wdata_r      <= pick_dm_s ? dm_wdata : {DATA_W{1'b0}};
                cnt_r        <= CNT_LOAD;
            end else if (state_r == ST_BUSY) begin
                if (cnt_r == CNT_ZERO) begin
                    if (grant_r == GNT_DM) begin
                        dm_ready_r <= 1'b1;
                        // A store leaves the load-data register untouched.
                        if (!we_r) begin
                            dm_rdata_r <= mem_rdata;
                        end else begin
                            dm_rdata_r <= dm_rdata_r;
                        end
                    end else begin
                        if_ready_r <= 1'b1;
                        if_rdata_r <= mem_rdata;
                    end
                end else begin
                    cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_ready  = if_ready_r;
    assign dm_ready  = dm_ready_r;
    assign stall_f   = if_req & ~if_ready_r;
    assign stall_m   = dm_req & ~dm_ready_r;
    assign mem_en    = mem_en_s;
    assign mem_we    = mem_we_s;
    assign mem_addr  = mem_addr_s;
    assign mem_wdata = mem_wdata_s;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed testbench for unified_mem_arbiter: a MEM_LAT=2 instance and a MEM_LAT=1 instance.
module tb_unified_mem_arbiter;

    logic        clk;
    logic        rst_n;

    // MEM_LAT = 2 instance
    logic        if_req, dm_req, dm_we;
    logic [31:0] if_addr, dm_addr, dm_wdata;
    logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        if_ready, dm_ready, stall_f, stall_m, mem_en, mem_we;

    // MEM_LAT = 1 instance
    logic        l1_if_req, l1_dm_req, l1_dm_we;
    logic [31:0] l1_if_addr, l1_dm_addr, l1_dm_wdata;
    logic [31:0] l1_if_rdata, l1_dm_rdata, l1_mem_addr, l1_mem_wdata, l1_mem_rdata;
    logic        l1_if_ready, l1_dm_ready, l1_stall_f, l1_stall_m, l1_mem_en, l1_mem_we;

    int checks;
    int errors;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready),
        .stall_f(stall_f), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(l1_if_req), .if_addr(l1_if_addr), .if_rdata(l1_if_rdata), .if_ready(l1_if_ready),
        .dm_req(l1_dm_req), .dm_we(l1_dm_we), .dm_addr(l1_dm_addr), .dm_wdata(l1_dm_wdata),
        .dm_rdata(l1_dm_rdata), .dm_ready(l1_dm_ready),
        .stall_f(l1_stall_f), .stall_m(l1_stall_m),
        .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr),
        .mem_wdata(l1_mem_wdata), .mem_rdata(l1_mem_rdata)
    );

    // Memory contents as seen by both instances.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        case (a)
            32'h0000_0040: mem_model = 32'h2010_0005;
            32'h0000_0010: mem_model = 32'h0000_00AA;
            32'h0000_0004: mem_model = 32'h1234_5678;
            default:       mem_model = a ^ 32'hA5A5_0000;
        endcase
    endfunction

    always_comb mem_rdata    = mem_model(mem_addr);
    always_comb l1_mem_rdata = mem_model(l1_mem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         n_we;
        int         n_rdy;
        int         ready_at;
        logic [3:0] order;
        int         n_grants;

        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0;
        l1_if_req = 1'b0; l1_if_addr = 32'd0;
        l1_dm_req = 1'b0; l1_dm_we = 1'b0; l1_dm_addr = 32'd0; l1_dm_wdata = 32'd0;

        // Reset state
        tick(); tick();
        chk1 ("rst_mem_en",   mem_en,   1'b0);
        chk1 ("rst_mem_we",   mem_we,   1'b0);
        chk32("rst_mem_addr", mem_addr, 32'd0);
        chk32("rst_if_rdata", if_rdata, 32'd0);
        chk32("rst_dm_rdata", dm_rdata, 32'd0);
        chk1 ("rst_if_ready", if_ready, 1'b0);
        chk1 ("rst_stall_f0", stall_f,  1'b0);
        if_req = 1'b1;
        #1;
        chk1 ("rst_stall_f1", stall_f,  1'b1);
        if_req = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();

        // Single fetch, MEM_LAT=2
        if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        chk1 ("f_stall_pre", stall_f, 1'b1);
        tick();
        chk1 ("f_en_c1",   mem_en,   1'b1);
        chk32("f_addr_c1", mem_addr, 32'h0000_0040);
        chk1 ("f_we_c1",   mem_we,   1'b0);
        chk1 ("f_rdy_c1",  if_ready, 1'b0);
        tick();
        chk1 ("f_en_c2",   mem_en,   1'b1);
        chk1 ("f_rdy_c2",  if_ready, 1'b0);
        chk1 ("f_stall_c2", stall_f, 1'b1);
        tick();
        chk1 ("f_rdy_c3",   if_ready, 1'b1);
        chk32("f_rdata",    if_rdata, 32'h2010_0005);
        chk1 ("f_en_c3",    mem_en,   1'b0);
        chk1 ("f_stall_c3", stall_f,  1'b0);
        if_req = 1'b0;
        tick();
        chk1 ("f_rdy_c4",   if_ready, 1'b0);
        chk1 ("f_en_c4",    mem_en,   1'b0);

        // Contention: DM load served first, IF granted at the following IDLE edge
        if_req = 1'b1; if_addr = 32'h0000_0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
        tick();
        chk32("c_addr_dm", mem_addr, 32'h0000_0010);
        tick();
        tick();
        chk1 ("c_dm_rdy",   dm_ready, 1'b1);
        chk32("c_dm_rdata", dm_rdata, 32'h0000_00AA);
        chk1 ("c_if_rdy0",  if_ready, 1'b0);
        chk1 ("c_stall_f",  stall_f,  1'b1);
        chk1 ("c_stall_m",  stall_m,  1'b0);
        dm_req = 1'b0;
        tick();
        chk1 ("c_idle_en",  mem_en,   1'b0);
        tick();
        chk1 ("c_if_en",    mem_en,   1'b1);
        chk32("c_addr_if",  mem_addr, 32'h0000_0040);
        tick();
        tick();
        chk1 ("c_if_rdy",   if_ready, 1'b1);
        chk1 ("c_dm_rdy0",  dm_ready, 1'b0);
        if_req = 1'b0;
        tick();

        // Sustained contention over 4 transactions: expect DM, IF, DM, IF
        if_req = 1'b1; if_addr = 32'h0000_0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0010;
        order = 4'd0; n_grants = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (dm_ready || if_ready) begin
                order = {order[2:0], dm_ready};
                n_grants++;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        chk32("s_grants", n_grants, 32'd4);
        chk32("s_order",  {28'd0, order}, 32'h0000_000A);
        tick();

        // Store: mem_we for exactly MEM_LAT cycles, dm_rdata unchanged
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0020; dm_wdata = 32'hDEAD_BEEF;
        n_we = 0; n_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (mem_we && mem_addr == 32'h0000_0020 && mem_wdata == 32'hDEAD_BEEF) n_we++;
            if (dm_ready) begin
                n_rdy++;
                dm_req = 1'b0;
            end
        end
        dm_we = 1'b0;
        chk32("st_we_cycles", n_we,     32'd2);
        chk32("st_ready_cnt", n_rdy,    32'd1);
        chk32("st_dm_rdata",  dm_rdata, 32'h0000_00AA);
        chk1 ("st_we_idle",   mem_we,   1'b0);

        // Reset during the first BUSY cycle of a fetch
        if_req = 1'b1; if_addr = 32'h0000_0040;
        tick();
        chk1 ("r_en_busy", mem_en, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1 ("r_en",       mem_en,   1'b0);
        chk1 ("r_we",       mem_we,   1'b0);
        chk32("r_addr",     mem_addr, 32'd0);
        chk32("r_if_rdata", if_rdata, 32'd0);
        chk32("r_dm_rdata", dm_rdata, 32'd0);
        n_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (if_ready) n_rdy++;
        end
        chk32("r_no_ready", n_rdy, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        ready_at = 0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (if_ready && ready_at == 0) begin
                ready_at = i;
                chk32("r_after_rdata", if_rdata, 32'h2010_0005);
                if_req = 1'b0;
            end
        end
        if_req = 1'b0;
        chk32("r_after_ready_at", ready_at, 32'd3);

        // MEM_LAT=1 instance: one BUSY cycle, address latched at grant
        l1_if_req = 1'b1; l1_if_addr = 32'h0000_0004;
        tick();
        chk1 ("l1_en",   l1_mem_en,   1'b1);
        chk32("l1_addr", l1_mem_addr, 32'h0000_0004);
        l1_if_addr = 32'h0000_0008;
        #1;
        chk32("l1_addr_hold", l1_mem_addr, 32'h0000_0004);
        tick();
        chk1 ("l1_rdy",   l1_if_ready, 1'b1);
        chk32("l1_rdata", l1_if_rdata, 32'h1234_5678);
        chk1 ("l1_en_off", l1_mem_en,  1'b0);
        l1_if_req = 1'b0;
        tick();
        chk1 ("l1_rdy_off", l1_if_ready, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
